// File: rtl/hft_rx_pkg.sv
// hft_rx_pkg: shared types and constants for the quote receive path
// (frame assembler, rx demux and system-level blocks).
package hft_rx_pkg;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned PAYLOAD_BYTES     = 16;
    localparam int unsigned PAYLOAD_W         = 8 * PAYLOAD_BYTES;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ADDR    = 2'd1,
        PAYLOAD = 2'd2,
        CSUM    = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] buyprice;
        logic [31:0] sellprice;
        logic [31:0] buyvol;
        logic [31:0] sellvol;
    } quote_t;

    // Payload arrives MSB-first, so the first field received ends up on top.
    function automatic quote_t to_quote(input logic [7:0]           a,
                                        input logic [PAYLOAD_W-1:0] p);
        quote_t q;
        q.addr      = a;
        q.buyprice  = p[127:96];
        q.sellprice = p[95:64];
        q.buyvol    = p[63:32];
        q.sellvol   = p[31:0];
        return q;
    endfunction

endpackage

// File: rtl/rx_byte_timer.sv
// rx_byte_timer: inter-byte watchdog. Counts cycles since the last byte while
// running and flags expiry on the cycle the gap reaches LIMIT.
module rx_byte_timer #(
    parameter int unsigned LIMIT = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int unsigned W    = (LIMIT < 2) ? 2 : $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    // The byte cycle itself counts as elapsed, so the count equals the gap
    // length and a strobe on the expiry cycle still wins.
    assign expire_o = run_i && !clear_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = ONE;
        end else if (!run_i || expire_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_frame_assembler.sv
// rx_frame_assembler: hunts for SYNC_BYTE, assembles an address + 4x32-bit quote,
// drops stalled frames. Define RX_FRAME_CSUM_EN to add the trailing XOR checksum byte.
module rx_frame_assembler
    import hft_rx_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_byte,
    input  logic             rx_byte_dv,
    output logic [7:0]       addr,
    output logic [31:0]      rx_buyprice,
    output logic [31:0]      rx_sellprice,
    output logic [31:0]      rx_buyvol,
    output logic [31:0]      rx_sellvol,
    output logic             rx_dv,
    output logic             csum_err,
    output logic             timeout_err,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_BYTES - 1);

    rx_state_e            state_q, state_d;
    logic [7:0]           addr_sh_q, addr_sh_d;
    logic [PAYLOAD_W-1:0] shadow_q, shadow_d;
    logic [3:0]           idx_q, idx_d;
    quote_t               quote_q, quote_d;
    logic                 rx_dv_q, rx_dv_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]     good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic                 frame_good, frame_bad, timer_expire;
`ifdef RX_FRAME_CSUM_EN
    logic [7:0]           acc_q, acc_d;
    logic                 csum_err_q, csum_err_d;
`endif

    rx_byte_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .run_i    (state_q != HUNT),
        .clear_i  (rx_byte_dv),
        .expire_o (timer_expire)
    );

    always_comb begin
        state_d       = state_q;
        addr_sh_d     = addr_sh_q;
        shadow_d      = shadow_q;
        idx_d         = idx_q;
        quote_d       = quote_q;
        rx_dv_d       = 1'b0;
        timeout_err_d = 1'b0;
        good_cnt_d    = good_cnt_q;
        err_cnt_d     = err_cnt_q;
        frame_good    = 1'b0;
        frame_bad     = 1'b0;
`ifdef RX_FRAME_CSUM_EN
        acc_d         = acc_q;
        csum_err_d    = 1'b0;
`endif

        if (rx_byte_dv) begin
            case (state_q)
                HUNT: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d = ADDR;
                    end
                end
                ADDR: begin
                    addr_sh_d = rx_byte;
                    idx_d     = '0;
                    state_d   = PAYLOAD;
`ifdef RX_FRAME_CSUM_EN
                    acc_d     = rx_byte;
`endif
                end
                PAYLOAD: begin
                    shadow_d = {shadow_q[PAYLOAD_W-9:0], rx_byte};
                    idx_d    = idx_q + 4'd1;
`ifdef RX_FRAME_CSUM_EN
                    acc_d    = acc_q ^ rx_byte;
                    if (idx_q == LAST_IDX) begin
                        state_d = CSUM;
                    end
`else
                    if (idx_q == LAST_IDX) begin
                        frame_good = 1'b1;
                        state_d    = HUNT;
                    end
`endif
                end
`ifdef RX_FRAME_CSUM_EN
                CSUM: begin
                    if (rx_byte == acc_q) begin
                        frame_good = 1'b1;
                    end else begin
                        frame_bad  = 1'b1;
                        csum_err_d = 1'b1;
                    end
                    state_d = HUNT;
                end
`endif
                default: state_d = HUNT;
            endcase
        end else if (timer_expire) begin
            state_d       = HUNT;
            timeout_err_d = 1'b1;
        end

        // shadow_d already holds the final payload byte in the no-checksum build.
        if (frame_good) begin
            quote_d    = to_quote(addr_sh_q, shadow_d);
            rx_dv_d    = 1'b1;
            good_cnt_d = (good_cnt_q == '1) ? good_cnt_q : good_cnt_q + 1'b1;
        end
        if (frame_bad || timeout_err_d) begin
            err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HUNT;
            addr_sh_q     <= '0;
            shadow_q      <= '0;
            idx_q         <= '0;
            quote_q       <= '0;
            rx_dv_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            good_cnt_q    <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            addr_sh_q     <= addr_sh_d;
            shadow_q      <= shadow_d;
            idx_q         <= idx_d;
            quote_q       <= quote_d;
            rx_dv_q       <= rx_dv_d;
            timeout_err_q <= timeout_err_d;
            good_cnt_q    <= good_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

`ifdef RX_FRAME_CSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= '0;
            csum_err_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            csum_err_q <= csum_err_d;
        end
    end

    assign csum_err = csum_err_q;
`else
    assign csum_err = 1'b0;
`endif

    assign addr         = quote_q.addr;
    assign rx_buyprice  = quote_q.buyprice;
    assign rx_sellprice = quote_q.sellprice;
    assign rx_buyvol    = quote_q.buyvol;
    assign rx_sellvol   = quote_q.sellvol;
    assign rx_dv        = rx_dv_q;
    assign timeout_err  = timeout_err_q;
    assign good_cnt     = good_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_rx_frame_assembler.sv
// tb_rx_frame_assembler: directed + randomized byte streams checked every cycle
// against a queue-based frame model; a second instance covers counter saturation.
module tb_rx_frame_assembler;

    localparam int unsigned T = 50;
`ifdef RX_FRAME_CSUM_EN
    localparam int BODY = 18;
`else
    localparam int BODY = 17;
`endif

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_byte = '0;
    logic        rx_byte_dv = 1'b0;

    logic [7:0]  addr;
    logic [31:0] rx_buyprice, rx_sellprice, rx_buyvol, rx_sellvol;
    logic        rx_dv, csum_err, timeout_err;
    logic [15:0] good_cnt, err_cnt;

    logic [7:0]  s_addr;
    logic [31:0] s_bp, s_sp, s_bv, s_sv;
    logic        s_rx_dv, s_csum_err, s_timeout_err;
    logic [1:0]  s_good_cnt, s_err_cnt;

    int tests = 0;
    int fails = 0;

    // reference model state
    bit          in_frame = 1'b0;
    bq_t         body;
    int          cyc = 0;
    int          last_cyc = 0;
    int          good_n = 0;
    int          err_n = 0;
    bit          e_dv = 1'b0, e_cerr = 1'b0, e_terr = 1'b0;
    logic [7:0]  e_addr = '0;
    logic [31:0] e_bp = '0, e_sp = '0, e_bv = '0, e_sv = '0;

    always #5 clk = ~clk;

    rx_frame_assembler #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_byte      (rx_byte),
        .rx_byte_dv   (rx_byte_dv),
        .addr         (addr),
        .rx_buyprice  (rx_buyprice),
        .rx_sellprice (rx_sellprice),
        .rx_buyvol    (rx_buyvol),
        .rx_sellvol   (rx_sellvol),
        .rx_dv        (rx_dv),
        .csum_err     (csum_err),
        .timeout_err  (timeout_err),
        .good_cnt     (good_cnt),
        .err_cnt      (err_cnt)
    );

    rx_frame_assembler #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (2)
    ) dut_sat (
        .clk          (clk),
        .reset        (reset),
        .rx_byte      (rx_byte),
        .rx_byte_dv   (rx_byte_dv),
        .addr         (s_addr),
        .rx_buyprice  (s_bp),
        .rx_sellprice (s_sp),
        .rx_buyvol    (s_bv),
        .rx_sellvol   (s_sv),
        .rx_dv        (s_rx_dv),
        .csum_err     (s_csum_err),
        .timeout_err  (s_timeout_err),
        .good_cnt     (s_good_cnt),
        .err_cnt      (s_err_cnt)
    );

    function automatic int sat(input int n, input int m);
        return (n > m) ? m : n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame completes once BODY bytes after SYNC are in; body[0] is ADDR.
    task automatic finish_frame();
        bit ok;
        ok = 1'b1;
`ifdef RX_FRAME_CSUM_EN
        begin
            logic [7:0] x;
            x = '0;
            for (int i = 0; i < 17; i++) x ^= body[i];
            ok = (x == body[17]);
        end
`endif
        if (ok) begin
            e_addr = body[0];
            e_bp   = {body[1],  body[2],  body[3],  body[4]};
            e_sp   = {body[5],  body[6],  body[7],  body[8]};
            e_bv   = {body[9],  body[10], body[11], body[12]};
            e_sv   = {body[13], body[14], body[15], body[16]};
            e_dv   = 1'b1;
            good_n++;
        end else begin
            e_cerr = 1'b1;
            err_n++;
        end
        in_frame = 1'b0;
    endtask

    // Predicts the outputs visible in the cycle after the one just clocked.
    task automatic model_step(input bit dv, input logic [7:0] b);
        e_dv = 1'b0; e_cerr = 1'b0; e_terr = 1'b0;
        if (in_frame) begin
            if (dv) begin
                last_cyc = cyc;
                body.push_back(b);
                if (body.size() == BODY) finish_frame();
            end else if (cyc + 1 - last_cyc == int'(T)) begin
                in_frame = 1'b0;
                e_terr   = 1'b1;
                err_n++;
            end
        end else if (dv && b == 8'hA5) begin
            in_frame = 1'b1;
            body.delete();
            last_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic check_all();
        chk("rx_dv",       32'(rx_dv),        32'(e_dv));
        chk("csum_err",    32'(csum_err),     32'(e_cerr));
        chk("timeout_err", 32'(timeout_err),  32'(e_terr));
        chk("addr",        32'(addr),         32'(e_addr));
        chk("buyprice",    rx_buyprice,       e_bp);
        chk("sellprice",   rx_sellprice,      e_sp);
        chk("buyvol",      rx_buyvol,         e_bv);
        chk("sellvol",     rx_sellvol,        e_sv);
        chk("good_cnt",    32'(good_cnt),     32'(sat(good_n, 65535)));
        chk("err_cnt",     32'(err_cnt),      32'(sat(err_n, 65535)));
        chk("sat_rx_dv",   32'(s_rx_dv),      32'(e_dv));
        chk("sat_good",    32'(s_good_cnt),   32'(sat(good_n, 3)));
        chk("sat_err",     32'(s_err_cnt),    32'(sat(err_n, 3)));
    endtask

    task automatic tick(input bit dv, input logic [7:0] b);
        rx_byte_dv = dv;
        rx_byte    = b;
        @(posedge clk);
        model_step(dv, b);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        rx_byte_dv = 1'b0;
        @(posedge clk);
        in_frame = 1'b0; body.delete(); good_n = 0; err_n = 0;
        e_dv = 1'b0; e_cerr = 1'b0; e_terr = 1'b0;
        e_addr = '0; e_bp = '0; e_sp = '0; e_bv = '0; e_sv = '0;
        cyc++;
        #1;
        check_all();
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int idle);
        repeat (idle) tick(1'b0, 8'h00);
        tick(1'b1, b);
    endtask

    task automatic send_seq(input bq_t q, input int n, input int max_idle);
        for (int i = 0; i < n; i++) send_byte(q[i], $urandom_range(0, max_idle));
    endtask

    function automatic bq_t make_frame(input logic [7:0] a, input logic [31:0] bp,
                                       input logic [31:0] sp, input logic [31:0] bv,
                                       input logic [31:0] sv);
        bq_t          q;
        logic [7:0]   x;
        logic [127:0] p;
        p = {bp, sp, bv, sv};
        q.push_back(8'hA5);
        q.push_back(a);
        x = a;
        for (int i = 15; i >= 0; i--) begin
            q.push_back(p[i*8 +: 8]);
            x ^= p[i*8 +: 8];
        end
        q.push_back(x);
        return q;
    endfunction

    initial begin
        bq_t gf, bad, fr;
        gf = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h65,
               8'h00, 8'h00, 8'h03, 8'hE8, 8'h00, 8'h00, 8'h01, 8'hF4, 8'h1F};
        bad = gf;
        bad[18] = 8'h1E;

        do_reset();
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_good", 32'(good_cnt), 32'h0);

        // good frame, rx_dv exactly one cycle after the final frame byte
        send_seq(gf, BODY, 0);
        chk("dv_before_last", 32'(rx_dv), 32'h0);
        send_byte(gf[BODY], 0);
        chk("dv_latency", 32'(rx_dv), 32'h1);
        if (BODY == 17) send_byte(gf[18], 0);
        chk("gf_addr", 32'(addr), 32'd0);
        chk("gf_buyprice", rx_buyprice, 32'd100);
        chk("gf_sellprice", rx_sellprice, 32'd101);
        chk("gf_buyvol", rx_buyvol, 32'd1000);
        chk("gf_sellvol", rx_sellvol, 32'd500);
        chk("gf_good_cnt", 32'(good_cnt), 32'd1);

        // bad checksum (a valid 18-byte frame when the checksum is not built in)
        send_seq(bad, 19, 0);
`ifdef RX_FRAME_CSUM_EN
        chk("bad_err_cnt", 32'(err_cnt), 32'd1);
        chk("bad_good_cnt", 32'(good_cnt), 32'd1);
`else
        chk("bad_err_cnt", 32'(err_cnt), 32'd0);
        chk("bad_good_cnt", 32'(good_cnt), 32'd2);
`endif
        chk("bad_buyprice_held", rx_buyprice, 32'd100);

        // garbage before sync is ignored
        send_byte(8'h12, 1);
        send_byte(8'h34, 2);
        send_seq(gf, 19, 1);

        // stall after byte 7: pulse exactly T cycles after its strobe
        send_seq(gf, 8, 0);
        repeat (T - 2) tick(1'b0, 8'h00);
        chk("to_not_yet", 32'(timeout_err), 32'h0);
        tick(1'b0, 8'h00);
        chk("to_pulse", 32'(timeout_err), 32'h1);
        repeat (3) tick(1'b0, 8'h00);
        send_seq(gf, 19, 0);

        // byte strobe on the expiry cycle keeps the frame alive
        send_seq(gf, 6, 0);
        send_byte(gf[6], T - 2);
        chk("edge_no_to", 32'(timeout_err), 32'h0);
        for (int i = 7; i < 19; i++) send_byte(gf[i], 0);

        // one cycle later is a timeout
        send_seq(gf, 6, 0);
        send_byte(gf[6], T - 1);
        repeat (T + 2) tick(1'b0, 8'h00);

        // reset mid-frame, then a clean frame
        send_seq(gf, 10, 0);
        do_reset();
        send_seq(gf, 19, 0);
        chk("post_rst_good", 32'(good_cnt), 32'd1);

        // counter saturation
        do_reset();
        repeat (5) send_seq(gf, 19, 0);
        chk("sat_hold", 32'(s_good_cnt), 32'd3);
        chk("wide_five", 32'(good_cnt), 32'd5);

        // randomized frames: garbage, corruption, truncation, long gaps
        for (int f = 0; f < 40; f++) begin
            int kind, n, mi;
            logic [7:0] g;
            repeat ($urandom_range(0, 3)) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g, $urandom_range(0, 2));
            end
            fr = make_frame(8'($urandom_range(0, 255)), $urandom, $urandom, $urandom, $urandom);
            kind = $urandom_range(0, 9);
            n  = 19;
            mi = 2;
            if (kind <= 1) fr[$urandom_range(1, 18)] ^= 8'($urandom_range(1, 255));
            if (kind == 2) n = $urandom_range(2, 17);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 19) == 0) send_byte(fr[i], $urandom_range(T - 5, T + 2));
                else send_byte(fr[i], $urandom_range(0, mi));
            end
            if (n < 19 || fr[18] == 8'hA5) repeat (T + 2) tick(1'b0, 8'h00);
            else repeat (2) tick(1'b0, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rx_frame_assembler.md
Name: rx_frame_assembler

Overview:
- Sits between the UART byte receiver and the per-stock rx demultiplexer.
- Hunts for a sync byte, then assembles a fixed-length quote frame of address plus four 32-bit fields, checked by an XOR checksum.
- Presents the frame as parallel words with a one-cycle data-valid pulse.
- Drops malformed frames and stalled frames, and reports each drop.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1_000_000, maximum clk cycles allowed between consecutive bytes inside a frame.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_byte  in  8  byte from the UART receiver.
- rx_byte_dv  in  1  one-cycle strobe; rx_byte is valid on this cycle.
- addr  out  8  stock address of the last good frame.
- rx_buyprice  out  32  buy price.
- rx_sellprice  out  32  sell price.
- rx_buyvol  out  32  buy volume.
- rx_sellvol  out  32  sell volume.
- rx_dv  out  1  one-cycle pulse: a good frame is on the outputs.
- csum_err  out  1  one-cycle pulse: frame dropped on checksum mismatch.
- timeout_err  out  1  one-cycle pulse: frame dropped on inter-byte timeout.
- good_cnt  out  CNT_W  count of good frames, saturating.
- err_cnt  out  CNT_W  count of dropped frames (checksum or timeout), saturating.

Behaviour:
- Reset: all outputs 0, state HUNT, shift register, checksum accumulator and timer cleared.
- Reset asserted mid-frame abandons the frame silently; no error pulse, no counter change.
- Frame byte order: SYNC, ADDR, buyprice[31:24..7:0], sellprice MSB-first, buyvol MSB-first, sellvol MSB-first, CSUM. Total 19 bytes.
- CSUM is the XOR of ADDR and the 16 payload bytes; SYNC is excluded.
- Bytes are consumed only on cycles where rx_byte_dv=1.
- States:
  - HUNT: byte == SYNC_BYTE -> ADDR. Any other byte is ignored and does not count as an error.
  - ADDR: latch addr_shadow, acc := byte, byte index := 0 -> PAYLOAD.
  - PAYLOAD: shift byte into the 128-bit shadow register, acc ^= byte. After index 15 -> CSUM; otherwise index+1.
  - CSUM: if byte == acc, copy the shadow registers to the outputs and pulse rx_dv on the next cycle, good_cnt+1. Otherwise pulse csum_err, err_cnt+1, outputs unchanged. Either way -> HUNT.
- Latency: rx_dv and csum_err assert exactly 1 cycle after the CSUM byte strobe.
- Data outputs hold their values until the next good frame; they are never cleared after the pulse.
- rx_dv pulses are separated by at least 19 cycles, which satisfies the downstream 3-cycle re-arm gap.
- A SYNC_BYTE value arriving inside a frame is treated as data; there is no resync mid-frame.
- Timeout:
  - The timer counts clk cycles while state != HUNT and resets on every accepted byte.
  - On reaching TIMEOUT_CYCLES: -> HUNT, pulse timeout_err, err_cnt+1.
  - If a byte strobe and timer expiry fall on the same cycle, the byte wins: it is consumed and the timer resets.
- Counters saturate at all-ones and never wrap.
- A good frame and an error never occur on the same cycle, so only one counter increments per cycle.

Optional Feature:
- Macro RX_FRAME_CSUM_EN.
- Defined: behaviour as above; 19-byte frame with CSUM check.
- Undefined:
  - No CSUM byte; the frame is 18 bytes.
  - After payload index 15 the frame is good: rx_dv pulses 1 cycle after the last sellvol byte.
  - csum_err is tied to 0 and the accumulator logic is removed.
  - Timeout behaviour is unchanged.

Decomposition:
- Shared package hft_rx_pkg:
  - SYNC_BYTE default.
  - Payload byte count (16).
  - State enum {HUNT, ADDR, PAYLOAD, CSUM}.
  - A quote struct {addr, buyprice, sellprice, buyvol, sellvol}, to be reused by rx_mux and the system blocks.
- One natural sub-module: rx_byte_timer, the loadable inter-byte timeout counter with clear-on-byte and an expiry pulse.

Test Plan:
- Good frame: A5,00, 00 00 00 64, 00 00 00 65, 00 00 03 E8, 00 00 01 F4, CSUM 1F -> rx_dv one cycle after the 1F strobe; addr=0, buyprice=100, sellprice=101, buyvol=1000, sellvol=500, good_cnt=1.
- Bad checksum: same frame with CSUM 1E -> csum_err pulse, no rx_dv, outputs keep their previous values, err_cnt=1.
- Garbage then frame: bytes 12,34,A5 followed by the good frame body -> 12 and 34 ignored, frame accepted, err_cnt unchanged.
- Timeout: TIMEOUT_CYCLES=50, stop sending after byte 7 -> timeout_err pulse 50 cycles after byte 7, state HUNT; a following good frame is accepted.
- Edge timing: a byte strobe on exactly the expiry cycle -> no timeout, frame continues. Reset asserted at byte 10 -> no pulses; the next frame is accepted.
- Saturation: CNT_W=2, send 5 good frames -> good_cnt holds at 3. Repeat with RX_FRAME_CSUM_EN undefined using the 18-byte frame -> rx_dv after the last F4 byte.
